// File: rtl/internal_cell.sv
// internal_cell: systolic-array QR internal cell. Applies a Givens rotation to
// the stored R element using one shared FP multiplier and one shared FP adder.
`default_nettype none

module internal_cell (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x_in,
  input  logic [31:0] c_in,
  input  logic [31:0] s_in,
  input  logic        valid_in,
  output logic [31:0] x_out,
  output logic [31:0] c_out,
  output logic [31:0] s_out,
  output logic        valid_out,
  output logic [31:0] r,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0, MUL0 = 3'd1, MUL1 = 3'd2, MUL2 = 3'd3,
    MUL3 = 3'd4, ADD0 = 3'd5, ADD1 = 3'd6, DONE = 3'd7
  } state_t;

  // Truncating single-precision multiply; zero operands and underflow give +0.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    logic [47:0]       prod;
    logic [22:0]       m;
    logic signed [9:0] e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'd0;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {s, 8'hFF, 23'd0};
    prod = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (prod[47]) begin
      m = prod[46:24];
      e = e + 10'sd1;
    end else begin
      m = prod[45:23];
    end
    if (e >= 10'sd255) return {s, 8'hFF, 23'd0};
    if (e <= 10'sd0) return 32'd0;
    return {s, e[7:0], m};
  endfunction

  // Truncating single-precision add/sub. Guard/round bits plus a sticky bit
  // keep the truncated result exact even across large alignment shifts.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b,
                                         input logic sub);
    logic              sa, sb, sl, ss, found;
    logic [7:0]        el, es, d;
    logic [26:0]       ml, ms, sh, diff, norm;
    logic [27:0]       sum;
    logic [22:0]       m;
    logic [4:0]        lz;
    logic signed [9:0] e;
    sa = a[31];
    sb = b[31] ^ sub;
    if (a[30:23] == 8'hFF && b[30:23] == 8'hFF)
      return (sa != sb) ? 32'h7F80_0000 : {sa, 8'hFF, 23'd0};
    if (a[30:23] == 8'hFF) return {sa, 8'hFF, 23'd0};
    if (b[30:23] == 8'hFF) return {sb, 8'hFF, 23'd0};
    if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {sa & sb, 31'd0};
    if (a[30:23] == 8'd0) return {sb, b[30:0]};
    if (b[30:23] == 8'd0) return a;
    if (b[30:0] > a[30:0]) begin
      sl = sb; el = b[30:23]; ml = {1'b1, b[22:0], 3'b000};
      ss = sa; es = a[30:23]; ms = {1'b1, a[22:0], 3'b000};
    end else begin
      sl = sa; el = a[30:23]; ml = {1'b1, a[22:0], 3'b000};
      ss = sb; es = b[30:23]; ms = {1'b1, b[22:0], 3'b000};
    end
    d = el - es;
    if (d >= 8'd27) begin
      sh = 27'd1;
    end else begin
      sh = ms >> d;
      if (|(ms & ~({27{1'b1}} << d))) sh[0] = 1'b1;
    end
    e = $signed({2'b00, el});
    if (sl == ss) begin
      sum = {1'b0, ml} + {1'b0, sh};
      if (sum[27]) begin
        m = sum[26:4];
        e = e + 10'sd1;
      end else begin
        m = sum[25:3];
      end
    end else begin
      diff = ml - sh;
      if (diff == 27'd0) return 32'd0;
      lz = 5'd0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
        if (!found) begin
          if (diff[i]) found = 1'b1;
          else lz = lz + 5'd1;
        end
      end
      norm = diff << lz;
      m = norm[25:3];
      e = e - $signed({5'd0, lz});
    end
    if (e >= 10'sd255) return {sl, 8'hFF, 23'd0};
    if (e <= 10'sd0) return 32'd0;
    return {sl, e[7:0], m};
  endfunction

  state_t      state_q, state_d;
  logic [31:0] x_q, x_d, c_q, c_d, s_q, s_d, r_q, r_d;
  logic [31:0] p0_q, p0_d, p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic [31:0] xo_q, xo_d, co_q, co_d, so_q, so_d;
  logic        vo_q, vo_d, busy_q, busy_d;
  logic [31:0] mul_a, mul_b, mul_res, add_a, add_b, add_res;
  logic        add_sub;

  // Operand steering for the single shared multiplier and adder.
  always_comb begin
    mul_a   = c_q;
    mul_b   = r_q;
    add_a   = p0_q;
    add_b   = p1_q;
    add_sub = 1'b0;
    case (state_q)
      MUL1: begin mul_a = s_q; mul_b = x_q; end
      MUL2: begin mul_a = c_q; mul_b = x_q; end
      MUL3: begin mul_a = s_q; mul_b = r_q; end
      ADD1: begin add_a = p2_q; add_b = p3_q; add_sub = 1'b1; end
      default: ;
    endcase
    mul_res = fp_mul(mul_a, mul_b);
    add_res = fp_add(add_a, add_b, add_sub);
  end

  always_comb begin
    state_d = state_q;
    x_d = x_q;   c_d = c_q;   s_d = s_q;   r_d = r_q;
    p0_d = p0_q; p1_d = p1_q; p2_d = p2_q; p3_d = p3_q;
    xo_d = xo_q; co_d = co_q; so_d = so_q;
    vo_d = 1'b0;
    busy_d = busy_q;
    case (state_q)
      IDLE: if (valid_in) begin
        x_d = x_in; c_d = c_in; s_d = s_in;
        state_d = MUL0;
        busy_d = 1'b1;
      end
      MUL0: begin p0_d = mul_res; state_d = MUL1; end
      MUL1: begin p1_d = mul_res; state_d = MUL2; end
      MUL2: begin p2_d = mul_res; state_d = MUL3; end
      MUL3: begin p3_d = mul_res; state_d = ADD0; end
      ADD0: begin r_d = add_res; state_d = ADD1; end
      ADD1: begin
        xo_d = add_res; co_d = c_q; so_d = s_q;
        vo_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin state_d = IDLE; busy_d = 1'b0; end
      default: begin state_d = IDLE; busy_d = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q <= '0;  c_q <= '0;  s_q <= '0;  r_q <= '0;
      p0_q <= '0; p1_q <= '0; p2_q <= '0; p3_q <= '0;
      xo_q <= '0; co_q <= '0; so_q <= '0;
      vo_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;   c_q <= c_d;   s_q <= s_d;   r_q <= r_d;
      p0_q <= p0_d; p1_q <= p1_d; p2_q <= p2_d; p3_q <= p3_d;
      xo_q <= xo_d; co_q <= co_d; so_q <= so_d;
      vo_q <= vo_d;
      busy_q <= busy_d;
    end
  end

  assign x_out     = xo_q;
  assign c_out     = co_q;
  assign s_out     = so_q;
  assign valid_out = vo_q;
  assign r         = r_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_internal_cell.sv
// tb_internal_cell: directed and randomized checks of internal_cell against an
// exact-integer floating-point reference model with a transaction timeline.
`default_nettype none

module tb_internal_cell;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] x_in = '0, c_in = '0, s_in = '0;
  logic        valid_in = 1'b0;
  logic [31:0] x_out, c_out, s_out, r;
  logic        valid_out, busy;

  internal_cell dut (
    .clk(clk), .rst(rst), .x_in(x_in), .c_in(c_in), .s_in(s_in),
    .valid_in(valid_in), .x_out(x_out), .c_out(c_out), .s_out(s_out),
    .valid_out(valid_out), .r(r), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (valid_out) pulses <= pulses + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Exact value v * 2^e_lsb, truncated to single precision.
  function automatic logic [31:0] pack(input logic s, input logic [319:0] v, input int e_lsb);
    int p, be;
    logic [319:0] t;
    p = -1;
    for (int i = 0; i < 320; i++) if (v[i]) p = i;
    if (p < 0) return 32'd0;
    be = p + e_lsb + 127;
    if (be >= 255) return {s, 8'hFF, 23'd0};
    if (be <= 0) return 32'd0;
    if (p >= 23) t = v >> (p - 23);
    else t = v << (23 - p);
    return {s, be[7:0], t[22:0]};
  endfunction

  function automatic logic [31:0] m_mul(input logic [31:0] a, input logic [31:0] b);
    logic [319:0] va, vb;
    int ea, eb;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0 || eb == 0) return 32'd0;
    if (ea == 255 || eb == 255) return {a[31] ^ b[31], 8'hFF, 23'd0};
    va = {296'd0, 1'b1, a[22:0]};
    vb = {296'd0, 1'b1, b[22:0]};
    return pack(a[31] ^ b[31], va * vb, ea + eb - 300);
  endfunction

  function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic sa, sb;
    logic [319:0] va, vb;
    int ea, eb, emin;
    sa = a[31];
    sb = b[31] ^ sub;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 && eb == 255) return (sa != sb) ? 32'h7F80_0000 : {sa, 8'hFF, 23'd0};
    if (ea == 255) return {sa, 8'hFF, 23'd0};
    if (eb == 255) return {sb, 8'hFF, 23'd0};
    if (ea == 0 && eb == 0) return {sa & sb, 31'd0};
    if (ea == 0) return {sb, b[30:0]};
    if (eb == 0) return {sa, a[30:0]};
    emin = (ea < eb) ? ea : eb;
    va = {296'd0, 1'b1, a[22:0]} << (ea - emin);
    vb = {296'd0, 1'b1, b[22:0]} << (eb - emin);
    if (sa == sb) return pack(sa, va + vb, emin - 150);
    if (va == vb) return 32'd0;
    if (va > vb) return pack(sa, va - vb, emin - 150);
    return pack(sb, vb - va, emin - 150);
  endfunction

  // Timeline model: last accepted transaction and the values before/after it.
  logic        have = 1'b0;
  int          acc = 0;
  logic [31:0] rb = '0, xb = '0, cb = '0, sbv = '0;
  logic [31:0] ra = '0, xa = '0, ca = '0, sa_ = '0;

  always @(negedge clk) begin
    logic [31:0] er, ex, ec, es;
    logic ev, ebz;
    if (rst) begin
      er = '0; ex = '0; ec = '0; es = '0; ev = 1'b0; ebz = 1'b0;
    end else begin
      er  = (have && cyc >= acc + 6) ? ra : rb;
      ex  = (have && cyc >= acc + 7) ? xa : xb;
      ec  = (have && cyc >= acc + 7) ? ca : cb;
      es  = (have && cyc >= acc + 7) ? sa_ : sbv;
      ev  = have && (cyc == acc + 7);
      ebz = have && (cyc > acc) && (cyc <= acc + 7);
    end
    chk("r", r, er);
    chk("x_out", x_out, ex);
    chk("c_out", c_out, ec);
    chk("s_out", s_out, es);
    chk("valid_out", {31'd0, valid_out}, {31'd0, ev});
    chk("busy", {31'd0, busy}, {31'd0, ebz});
    if (rst) begin
      have = 1'b0;
      rb = '0; xb = '0; cb = '0; sbv = '0;
    end else if (valid_in && (!have || cyc >= acc + 8)) begin
      rb = er; xb = ex; cb = ec; sbv = es;
      ra  = m_add(m_mul(c_in, er), m_mul(s_in, x_in), 1'b0);
      xa  = m_add(m_mul(c_in, x_in), m_mul(s_in, er), 1'b1);
      ca  = c_in;
      sa_ = s_in;
      acc = cyc;
      have = 1'b1;
    end
  end

  function automatic logic [31:0] rnd_fp();
    int k;
    logic s;
    logic [22:0] m;
    logic [7:0] e;
    k = int'($urandom_range(0, 99));
    s = 1'($urandom);
    m = 23'($urandom);
    if (k < 10) return {s, 31'd0};
    if (k < 15) return {s, 8'd0, m};
    if (k < 19) return {s, 8'hFF, m};
    if (k < 25) e = 8'($urandom_range(200, 254));
    else if (k < 30) e = 8'($urandom_range(1, 30));
    else e = 8'($urandom_range(110, 144));
    return {s, e, m};
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic txn(input string tag, input logic [31:0] c, input logic [31:0] s,
                     input logic [31:0] x, input logic [31:0] er, input logic [31:0] ex);
    int k;
    @(posedge clk); #1;
    c_in = c; s_in = s; x_in = x; valid_in = 1'b1;
    @(negedge clk);
    k = 0;
    @(posedge clk); #1;
    valid_in = 1'b0;
    x_in = $urandom; c_in = $urandom; s_in = $urandom;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (valid_out) break;
    end
    chk({tag, " latency"}, k, 7);
    chk({tag, " r"}, r, er);
    chk({tag, " x_out"}, x_out, ex);
    chk({tag, " c_out"}, c_out, c);
    chk({tag, " s_out"}, s_out, s);
    @(negedge clk);
    chk({tag, " pulse width"}, {31'd0, valid_out}, 32'd0);
  endtask

  initial begin
    int p0;
    repeat (3) @(negedge clk);
    chk("reset r", r, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    txn("t1", 32'h0000_0000, 32'h3F80_0000, 32'h4090_0000, 32'h4090_0000, 32'h0000_0000);
    txn("t2", 32'h3F80_0000, 32'h0000_0000, 32'hC020_0000, 32'h4090_0000, 32'hC020_0000);
    txn("t3", 32'h3F00_0000, 32'h3F00_0000, 32'h4000_0000, 32'h4050_0000, 32'hBFA0_0000);

    // valid_in held high for 16 cycles: accepts at offsets 0 and 8 only.
    p0 = pulses;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      valid_in = 1'b1;
      x_in = rnd_fp(); c_in = rnd_fp(); s_in = rnd_fp();
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("back-to-back pulses", pulses - p0, 2);

    // Reset in the fourth cycle after acceptance aborts the transaction.
    p0 = pulses;
    @(posedge clk); #1;
    c_in = 32'h3F80_0000; s_in = 32'h3F80_0000; x_in = 32'h4000_0000; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort pulses", pulses - p0, 0);
    chk("abort r", r, 32'd0);
    txn("t5", 32'h0000_0000, 32'h3F80_0000, 32'h4120_0000, 32'h4120_0000, 32'h0000_0000);

    do_reset();
    txn("ovf", 32'h0000_0000, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 32'h0000_0000);
    do_reset();
    txn("load5", 32'h0000_0000, 32'h3F80_0000, 32'h40A0_0000, 32'h40A0_0000, 32'h0000_0000);
    txn("cancel", 32'h3F80_0000, 32'h3F80_0000, 32'h40A0_0000, 32'h4120_0000, 32'h0000_0000);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 199) == 0);
      valid_in = 1'($urandom);
      x_in = rnd_fp(); c_in = rnd_fp(); s_in = rnd_fp();
    end
    @(posedge clk); #1;
    rst = 1'b0;
    valid_in = 1'b0;
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/internal_cell.md
INTERNAL_CELL -- requirements
Module: internal_cell

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 x_in  input  32  IEEE-754 single element entering from the cell above.
REQ-005 c_in  input  32  IEEE-754 single cosine from the boundary cell or left neighbour.
REQ-006 s_in  input  32  IEEE-754 single sine from the boundary cell or left neighbour.
REQ-007 valid_in  input  1  x_in/c_in/s_in valid this cycle.
REQ-008 x_out  output  32  rotated element passed to the cell below.
REQ-009 c_out  output  32  registered copy of the accepted c_in, for the right neighbour.
REQ-010 s_out  output  32  registered copy of the accepted s_in, for the right neighbour.
REQ-011 valid_out  output  1  one-cycle pulse; x_out/c_out/s_out valid.
REQ-012 r  output  32  stored R-matrix element, IEEE-754 single.
REQ-013 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-014 Each transaction SHALL apply the Givens rotation r_new = c*r + s*x and x_out = c*x - s*r, using the old r in both terms.
REQ-015 The cell SHALL accept a transaction when valid_in=1 and FSM=IDLE, latching x, c and s.
REQ-016 valid_in while busy=1 SHALL be ignored: the transaction is dropped and there is no state change.
REQ-017 The FSM SHALL have the states IDLE, MUL0, MUL1, MUL2, MUL3, ADD0, ADD1 and DONE, and SHALL advance one state per cycle with no stalls.
REQ-018 The FSM SHALL compute, in order:
- MUL0: p0 = c*r
- MUL1: p1 = s*x
- MUL2: p2 = c*x
- MUL3: p3 = s*r_old
- ADD0: r_new = p0 + p1
- ADD1: x_res = p2 - p3
REQ-019 The implementation SHALL use exactly one shared FP multiplier and one shared FP adder/subtractor.
REQ-020 r SHALL update at the end of ADD0, and p3 SHALL already hold the old r at that point.
REQ-021 In DONE, the cell SHALL drive x_out = x_res, c_out = c and s_out = s, pulse valid_out=1 for exactly one cycle, and return to IDLE on the next cycle.
REQ-022 Latency: if the accept edge is cycle 0, valid_out SHALL be high in cycle 7.
REQ-023 Throughput: back-to-back valid_in SHALL allow at most one accepted transaction per 8 cycles. A valid_in arriving in the DONE cycle SHALL be dropped; acceptance resumes in IDLE.
REQ-024 x_out, c_out and s_out SHALL hold their values between valid_out pulses.
REQ-025 FP arithmetic rules:
- Denormal inputs SHALL be flushed to signed zero.
- Denormal results SHALL be flushed to +0.
- Rounding SHALL be truncation toward zero.
- An exact-cancellation sum SHALL yield +0.
- Any zero operand to the multiplier SHALL yield +0.
REQ-026 Exponent overflow SHALL saturate to signed infinity (exponent 255, mantissa 0). An input with exponent 255 SHALL be treated as infinity, and inf - inf SHALL yield +inf. NaN handling is not required.

Reset
REQ-027 While rst=1, the cell SHALL set FSM=IDLE, r=32'h00000000, x_out=c_out=s_out=32'h00000000, valid_out=0 and busy=0.
REQ-028 Reset asserted mid-transaction SHALL abort it: no valid_out pulse, r=0, and the next accept after release starts from clean state.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Reset, then r=0; c=0 (00000000), s=1.0 (3F800000), x=4.5 (40900000) -> cycle 7: r=40900000, x_out=00000000, c_out=00000000, s_out=3F800000, one-cycle valid_out.
- With r=4.5: c=1.0, s=0, x=-2.5 (C0200000) -> r=40900000, x_out=C0200000.
- With r=4.5: c=0.5 (3F000000), s=0.5, x=2.0 (40000000) -> r=3.25 (40500000), x_out=-1.25 (BFA00000).
- valid_in held high for 16 cycles -> exactly 2 transactions accepted (cycles 0 and 8), 2 valid_out pulses; inputs presented in cycles 1-7 have no effect.
- rst pulsed in cycle 4 of a transaction -> no valid_out, r=00000000; a following c=0, s=1.0, x=10.0 (41200000) gives r=41200000.
- Overflow: r=0, c=0, s=7F000000, x=7F000000 -> r=7F800000; and c=s=1.0, x=r=5.0 (40A00000) -> x_out=00000000 (exact cancellation gives +0).
